// File: rtl/pit_pkg.sv
// Shared definitions for the PIT data receive path: sizes, FSM state
// encoding and the name hash used for both interest insert and lookup.
package pit_pkg;

    localparam int PKT_BYTES  = 1024;
    localparam int HASH_W     = 10;
    localparam int PREFIX_W   = 64;
    localparam int LEN_W      = 6;
    localparam int DATA_W     = 8;
    localparam int DROP_W     = 16;
    localparam int TABLE_SIZE = 1 << HASH_W;
    localparam int CNT_W      = $clog2(PKT_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HASH   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RECV   = 2'd3
    } pit_state_t;

    // Fold the masked prefix (only bits [len-1:0] survive, len=0 keeps
    // nothing) into 10 bits by XOR of seven 10-bit slices, then mix in len.
    function automatic logic [HASH_W-1:0] pit_hash_fn(
        input logic [PREFIX_W-1:0] prefix,
        input logic [LEN_W-1:0]    len
    );
        logic [PREFIX_W-1:0] mask;
        logic [69:0]         ext;
        logic [HASH_W-1:0]   h;
        mask = (64'd1 << len) - 64'd1;
        ext  = {6'd0, prefix & mask};
        h    = {4'd0, len};
        for (int i = 0; i < 7; i++) begin
            h = h ^ ext[i*HASH_W +: HASH_W];
        end
        return h;
    endfunction

endpackage

// File: rtl/pit_hash.sv
// Registered one-cycle name hash. The caller selects which name is hashed
// each cycle; the result and a qualifier appear on the following cycle.
module pit_hash
    import pit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [LEN_W-1:0]    len,
    output logic [HASH_W-1:0]   hash,
    output logic                hash_valid
);

    // Hash register: captures the hash of the selected name when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hash       <= '0;
            hash_valid <= 1'b0;
        end else begin
            hash_valid <= en;
            if (en) begin
                hash <= pit_hash_fn(prefix, len);
            end
        end
    end

endmodule

// File: rtl/pit_data_rx.sv
// PIT data receiver: keeps a hashed table of pending interests, checks each
// offered data packet against it and, on a hit, streams 1024 payload bytes.
// Optional feature macro: PIT_DROP_CNT_EN enables the saturating drop counter.
//
// Handshake: interest_valid and prefix_ready are single-cycle strobes with no
// back-pressure; an offer is taken only in IDLE and answered by exactly one
// of rejected/start_send_to_pit three cycles later. Offers seen in any other
// state are dropped silently. out_valid qualifies out_data for one cycle per
// byte; the consumer cannot stall the stream.
module pit_data_rx
    import pit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                interest_valid,
    input  logic [PREFIX_W-1:0] interest_prefix,
    input  logic [LEN_W-1:0]    interest_len,
    input  logic                prefix_ready,
    input  logic [PREFIX_W-1:0] fib_prefix,
    input  logic [LEN_W-1:0]    fib_len,
    input  logic [DATA_W-1:0]   data_in,
    output logic                rejected,
    output logic                start_send_to_pit,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic                pkt_done,
    output logic [DROP_W-1:0]   drop_count,
    output pit_state_t          fsm_state
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);

    pit_state_t            state;
    pit_state_t            state_next;

    logic [PREFIX_W-1:0]   name_prefix;
    logic [LEN_W-1:0]      name_len;

    logic                  hold_valid;
    logic [PREFIX_W-1:0]   hold_prefix;
    logic [LEN_W-1:0]      hold_len;
    logic                  hold_load;

    logic                  hash_en;
    logic [PREFIX_W-1:0]   hash_prefix;
    logic [LEN_W-1:0]      hash_len;
    logic                  hash_insert;
    logic                  hash_insert_q;
    logic [HASH_W-1:0]     hash_q;
    logic                  hash_v;

    logic [TABLE_SIZE-1:0] pend_q;
    logic                  set_en;
    logic                  hit;
    logic                  clear_en;
    logic                  accept;
    logic                  reject;
    logic                  sample;
    logic                  byte_last;

    logic [CNT_W-1:0]      byte_cnt;

    assign fsm_state = state;

    // Hasher input select: the lookup owns the hasher in HASH; an interest
    // arriving then is parked in the hold register and hashed next cycle.
    always_comb begin
        hash_en     = 1'b0;
        hash_prefix = '0;
        hash_len    = '0;
        hash_insert = 1'b0;
        hold_load   = 1'b0;
        if (state == ST_HASH) begin
            hash_en     = 1'b1;
            hash_prefix = name_prefix;
            hash_len    = name_len;
            hold_load   = interest_valid;
        end else if (hold_valid) begin
            hash_en     = 1'b1;
            hash_prefix = hold_prefix;
            hash_len    = hold_len;
            hash_insert = 1'b1;
            hold_load   = interest_valid;
        end else if (interest_valid) begin
            hash_en     = 1'b1;
            hash_prefix = interest_prefix;
            hash_len    = interest_len;
            hash_insert = 1'b1;
        end
    end

    pit_hash u_hash (
        .clk        (clk),
        .rst        (rst),
        .en         (hash_en),
        .prefix     (hash_prefix),
        .len        (hash_len),
        .hash       (hash_q),
        .hash_valid (hash_v)
    );

    // Hold register for a deferred interest plus the insert/lookup tag that
    // travels alongside the registered hash.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid    <= 1'b0;
            hold_prefix   <= '0;
            hold_len      <= '0;
            hash_insert_q <= 1'b0;
        end else begin
            hash_insert_q <= hash_insert;
            if (hold_load) begin
                hold_valid  <= 1'b1;
                hold_prefix <= interest_prefix;
                hold_len    <= interest_len;
            end else if (state != ST_HASH) begin
                hold_valid  <= 1'b0;
            end
        end
    end

    assign set_en = hash_v && hash_insert_q;
    assign hit    = pend_q[hash_q];

    // Pending-interest table: the set is applied after the clear so a
    // simultaneous set and clear of the same entry leaves it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            if (clear_en) begin
                pend_q[hash_q] <= 1'b0;
            end
            if (set_en) begin
                pend_q[hash_q] <= 1'b1;
            end
        end
    end

    // Latch the offered name when an offer is taken in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            name_prefix <= '0;
            name_len    <= '0;
        end else if (state == ST_IDLE && prefix_ready) begin
            name_prefix <= fib_prefix;
            name_len    <= fib_len;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and per-cycle decisions. The first RECV cycle is the
    // one carrying the start_send_to_pit pulse, so sampling starts after it.
    always_comb begin
        state_next = state;
        clear_en   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        sample     = 1'b0;
        byte_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prefix_ready) begin
                    state_next = ST_HASH;
                end
            end
            ST_HASH: begin
                state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    accept     = 1'b1;
                    clear_en   = 1'b1;
                    state_next = ST_RECV;
                end else begin
                    reject     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RECV: begin
                sample    = !start_send_to_pit;
                byte_last = sample && (byte_cnt == LAST_BYTE);
                if (byte_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered response pulses, payload output and byte counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rejected          <= 1'b0;
            start_send_to_pit <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_last          <= 1'b0;
            pkt_done          <= 1'b0;
            byte_cnt          <= '0;
        end else begin
            rejected          <= reject;
            start_send_to_pit <= accept;
            out_valid         <= sample;
            out_data          <= sample ? data_in : '0;
            out_last          <= byte_last;
            pkt_done          <= out_last;
            if (sample) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

`ifdef PIT_DROP_CNT_EN
    logic              busy;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_q;

    assign busy     = prefix_ready && (state != ST_IDLE);
    assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(reject) + (DROP_W+1)'(busy);

    // Saturating drop counter: rejections plus offers seen while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pit_data_rx.sv
// Directed bench for pit_data_rx: accept/reject timing, payload stream,
// busy drops, reset during receive and re-registration in the accept cycle.
module tb_pit_data_rx;
    import pit_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                interest_valid = 1'b0;
    logic [PREFIX_W-1:0] interest_prefix = '0;
    logic [LEN_W-1:0]    interest_len = '0;
    logic                prefix_ready = 1'b0;
    logic [PREFIX_W-1:0] fib_prefix = '0;
    logic [LEN_W-1:0]    fib_len = '0;
    logic [DATA_W-1:0]   data_in = '0;
    logic                rejected;
    logic                start_send_to_pit;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_last;
    logic                pkt_done;
    logic [DROP_W-1:0]   drop_count;
    pit_state_t          fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    pit_data_rx dut (
        .clk               (clk),
        .rst               (rst),
        .interest_valid    (interest_valid),
        .interest_prefix   (interest_prefix),
        .interest_len      (interest_len),
        .prefix_ready      (prefix_ready),
        .fib_prefix        (fib_prefix),
        .fib_len           (fib_len),
        .data_in           (data_in),
        .rejected          (rejected),
        .start_send_to_pit (start_send_to_pit),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_last          (out_last),
        .pkt_done          (pkt_done),
        .drop_count        (drop_count),
        .fsm_state         (fsm_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_drop(input int n);
`ifdef PIT_DROP_CNT_EN
        exp_drop = exp_drop + n;
`else
        exp_drop = exp_drop + 0 * n;
`endif
    endtask

    task automatic add_interest(input logic [63:0] p, input logic [5:0] l);
        interest_prefix = p;
        interest_len    = l;
        interest_valid  = 1'b1;
        step();
        interest_valid  = 1'b0;
        step();
        step();
        step();
    endtask

    // Offer a name; check silence for two cycles and the response on the third.
    task automatic offer(input logic [63:0] p, input logic [5:0] l,
                         input bit exp_accept, input bit interest_in_lookup);
        fib_prefix   = p;
        fib_len      = l;
        prefix_ready = 1'b1;
        step();
        prefix_ready = 1'b0;
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b00) begin
            n_err++;
            $display("FAIL offer_quiet1: got %b required 00", {rejected, start_send_to_pit});
        end
        step();
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b00) begin
            n_err++;
            $display("FAIL offer_quiet2: got %b required 00", {rejected, start_send_to_pit});
        end
        if (interest_in_lookup) begin
            interest_prefix = p;
            interest_len    = l;
            interest_valid  = 1'b1;
        end
        step();
        interest_valid = 1'b0;
        n_cmp++;
        if (start_send_to_pit !== exp_accept) begin
            n_err++;
            $display("FAIL offer_start: got %b required %b", start_send_to_pit, exp_accept);
        end
        n_cmp++;
        if (rejected !== !exp_accept) begin
            n_err++;
            $display("FAIL offer_reject: got %b required %b", rejected, !exp_accept);
        end
        if (!exp_accept) begin
            note_drop(1);
            step();
            n_cmp++;
            if ({rejected, start_send_to_pit} !== 2'b00 || fsm_state !== ST_IDLE) begin
                n_err++;
                $display("FAIL offer_after: got pulses %b state %0d required 00 state 0",
                         {rejected, start_send_to_pit}, fsm_state);
            end
        end
    endtask

    // Stream the payload following an accept; optional busy offer or reset.
    task automatic recv_payload(input int busy_at, input int rst_at);
        data_in = 8'hEE;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || start_send_to_pit !== 1'b0) begin
            n_err++;
            $display("FAIL recv_early: got valid %b start %b required 0 0", out_valid, start_send_to_pit);
        end
        for (int k = 0; k < PKT_BYTES; k++) begin
            data_in = 8'(k);
            if (k == busy_at) prefix_ready = 1'b1;
            if (k == rst_at)  rst = 1'b0;
            step();
            prefix_ready = 1'b0;
            if (k == busy_at) note_drop(1);
            if (k == rst_at) begin
                rst = 1'b1;
                exp_drop = 0;
                n_cmp++;
                if ({out_valid, out_last, pkt_done, rejected, start_send_to_pit} !== 5'b0 ||
                    out_data !== 8'h00 || drop_count !== 16'h0 || fsm_state !== ST_IDLE) begin
                    n_err++;
                    $display("FAIL rst_outputs: got flags %b data %0h drops %0d state %0d required 0",
                             {out_valid, out_last, pkt_done, rejected, start_send_to_pit},
                             out_data, drop_count, fsm_state);
                end
                for (int j = k + 1; j < PKT_BYTES + 3; j++) begin
                    data_in = 8'(j);
                    step();
                    n_cmp++;
                    if ({out_valid, out_last, pkt_done} !== 3'b000) begin
                        n_err++;
                        $display("FAIL rst_ignore j=%0d: got %b required 000", j,
                                 {out_valid, out_last, pkt_done});
                    end
                end
                return;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_last !== (k == PKT_BYTES - 1)) begin
                n_err++;
                $display("FAIL byte %0d: got valid %b data %0h last %b required 1 %0h %b",
                         k, out_valid, out_data, out_last, 8'(k), (k == PKT_BYTES - 1));
            end
            n_cmp++;
            if ({rejected, start_send_to_pit, pkt_done} !== 3'b000) begin
                n_err++;
                $display("FAIL recv_pulses %0d: got %b required 000", k,
                         {rejected, start_send_to_pit, pkt_done});
            end
        end
        data_in = 8'h00;
        step();
        n_cmp++;
        if (pkt_done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL pkt_done: got done %b valid %b last %b required 1 0 0",
                     pkt_done, out_valid, out_last);
        end
        step();
        n_cmp++;
        if (pkt_done !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL pkt_done_end: got done %b state %0d required 0 0", pkt_done, fsm_state);
        end
    endtask

    task automatic check_drops(input string tag);
        n_cmp++;
        if (drop_count !== 16'(exp_drop)) begin
            n_err++;
            $display("FAIL drops_%s: got %0d required %0d", tag, drop_count, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({rejected, start_send_to_pit, out_valid, out_last, pkt_done} !== 5'b0 ||
            out_data !== 8'h00 || drop_count !== 16'h0 || fsm_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got flags %b data %0h drops %0d state %0d required 0",
                     {rejected, start_send_to_pit, out_valid, out_last, pkt_done},
                     out_data, drop_count, fsm_state);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_accept();
        add_interest(64'h1234, 6'd16);
        offer(64'h1234, 6'd16, 1'b1, 1'b0);
        recv_payload(-1, -1);
        check_drops("accept");
    endtask

    task automatic test_reject();
        offer(64'hDEAD, 6'd16, 1'b0, 1'b0);
        check_drops("reject");
    endtask

    task automatic test_repeat_after_done();
        offer(64'h1234, 6'd16, 1'b0, 1'b0);
        check_drops("repeat");
    endtask

    task automatic test_mask_and_busy();
        add_interest(64'h1234, 6'd16);
        offer(64'h1234, 6'd12, 1'b0, 1'b0);
        offer(64'hABCD_0000_0000_1234, 6'd16, 1'b1, 1'b0);
        recv_payload(500, -1);
        check_drops("busy");
    endtask

    task automatic test_lookup_busy();
        fib_prefix   = 64'hDEAD;
        fib_len      = 6'd16;
        prefix_ready = 1'b1;
        step();
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b00) begin
            n_err++;
            $display("FAIL lb_quiet1: got %b required 00", {rejected, start_send_to_pit});
        end
        step();
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b00) begin
            n_err++;
            $display("FAIL lb_quiet2: got %b required 00", {rejected, start_send_to_pit});
        end
        step();
        prefix_ready = 1'b0;
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b10) begin
            n_err++;
            $display("FAIL lb_response: got %b required 10", {rejected, start_send_to_pit});
        end
        note_drop(3);
        step();
        n_cmp++;
        if ({rejected, start_send_to_pit} !== 2'b00 || fsm_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL lb_after: got %b state %0d required 00 state 0",
                     {rejected, start_send_to_pit}, fsm_state);
        end
        step();
        check_drops("lookup_busy");
    endtask

    task automatic test_reset_mid_recv();
        add_interest(64'h1234, 6'd16);
        offer(64'h1234, 6'd16, 1'b1, 1'b0);
        recv_payload(-1, 10);
        offer(64'h1234, 6'd16, 1'b0, 1'b0);
        check_drops("reset_mid");
    endtask

    task automatic test_back_to_back();
        add_interest(64'h1234, 6'd16);
        offer(64'h1234, 6'd16, 1'b1, 1'b1);
        recv_payload(-1, -1);
        offer(64'h1234, 6'd16, 1'b1, 1'b0);
        recv_payload(-1, -1);
        check_drops("b2b");
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_repeat_after_done();
        test_mask_and_busy();
        test_lookup_busy();
        test_reset_mid_recv();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
